// File: rtl/rtc_evt_pkg.sv
// Shared types for the RTC event logger: timestamp widths and the stored entry format.
// The entry carries an 8-bit sequence number only when RTC_EVT_LOG_SEQ_EN is defined.
package rtc_evt_pkg;

  localparam int unsigned RTC_DATE_W  = 32;
  localparam int unsigned RTC_CLOCK_W = 22;
  localparam int unsigned SEQ_W       = 8;

  typedef struct packed {
`ifdef RTC_EVT_LOG_SEQ_EN
    logic [SEQ_W-1:0]       seq;
`endif
    logic [RTC_DATE_W-1:0]  date;
    logic [RTC_CLOCK_W-1:0] clock;
  } rtc_ts_t;

endpackage

// File: rtl/rtc_evt_fifo.sv
// Synchronous FIFO of rtc_ts_t entries with wrapping pointers and a separate occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module rtc_evt_fifo
  import rtc_evt_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  rtc_ts_t          wdata_i,
  output rtc_ts_t          rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  rtc_ts_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the read side is qualified by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr];
  assign count_o = count_q;

endmodule

// File: rtl/rtc_evt_log.sv
// Timestamped RTC event logger: edge-detects event_i, queues {date, clock}, flags drops, raises irq.
// Define RTC_EVT_LOG_SEQ_EN to add an 8-bit per-event sequence number and the seq_o port.
module rtc_evt_log
  import rtc_evt_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   event_i,
  input  logic [RTC_DATE_W-1:0]  date_i,
  input  logic [RTC_CLOCK_W-1:0] clock_i,
  input  logic                   irq_enable_i,
  input  logic                   pop_i,
  input  logic                   clear_overflow_i,
  output logic                   valid_o,
  output logic [RTC_DATE_W-1:0]  ts_date_o,
  output logic [RTC_CLOCK_W-1:0] ts_clock_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   overflow_o,
`ifdef RTC_EVT_LOG_SEQ_EN
  output logic [SEQ_W-1:0]       seq_o,
`endif
  output logic                   irq_o
);

  logic             evt_q;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  logic             overflow_q;
  logic             irq_q;
  logic [CNT_W-1:0] count;
  rtc_ts_t          wdata;
  rtc_ts_t          head;

  assign push = event_i & ~evt_q;
  // A full FIFO only loses the push when no pop frees a slot in the same cycle.
  assign drop = push & full & ~pop_i;

`ifdef RTC_EVT_LOG_SEQ_EN
  logic [SEQ_W-1:0] seq_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i)   seq_q <= '0;
    else if (push) seq_q <= seq_q + SEQ_W'(1);
  end
`endif

  always_comb begin
    wdata       = '0;
    wdata.date  = date_i;
    wdata.clock = clock_i;
`ifdef RTC_EVT_LOG_SEQ_EN
    wdata.seq   = seq_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      evt_q      <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      evt_q <= event_i;
      if (drop)                  overflow_q <= 1'b1;
      else if (clear_overflow_i) overflow_q <= 1'b0;
      irq_q <= irq_enable_i & ((count != '0) | overflow_q);
    end
  end

  rtc_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (pop_i),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign valid_o    = ~empty;
  assign ts_date_o  = empty ? '0 : head.date;
  assign ts_clock_o = empty ? '0 : head.clock;
  assign count_o    = count;
  assign overflow_o = overflow_q;
  assign irq_o      = irq_q;
`ifdef RTC_EVT_LOG_SEQ_EN
  assign seq_o      = empty ? '0 : head.seq;
`endif

endmodule

// File: tb/tb_rtc_evt_log.sv
// Bench for rtc_evt_log: directed scenarios then random traffic against a queue-based model.
// Sequence-number checks are active when RTC_EVT_LOG_SEQ_EN is defined.
module tb_rtc_evt_log;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        event_i = 1'b0;
  logic [31:0] date_i = '0;
  logic [21:0] clock_i = '0;
  logic        irq_enable_i = 1'b0;
  logic        pop_i = 1'b0;
  logic        clear_overflow_i = 1'b0;
  logic        valid_o;
  logic [31:0] ts_date_o;
  logic [21:0] ts_clock_o;
  logic [2:0]  count_o;
  logic        overflow_o;
  logic        irq_o;
  logic [7:0]  seq_o;

  int checks = 0;
  int failures = 0;

  rtc_evt_log #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .event_i          (event_i),
    .date_i           (date_i),
    .clock_i          (clock_i),
    .irq_enable_i     (irq_enable_i),
    .pop_i            (pop_i),
    .clear_overflow_i (clear_overflow_i),
    .valid_o          (valid_o),
    .ts_date_o        (ts_date_o),
    .ts_clock_o       (ts_clock_o),
    .count_o          (count_o),
    .overflow_o       (overflow_o),
`ifdef RTC_EVT_LOG_SEQ_EN
    .seq_o            (seq_o),
`endif
    .irq_o            (irq_o)
  );

`ifndef RTC_EVT_LOG_SEQ_EN
  assign seq_o = '0;
`endif

  always #5 clk = ~clk;

  // Reference model: the log is a plain queue of timestamps
  typedef struct {
    logic [31:0] d;
    logic [21:0] c;
    logic [7:0]  s;
  } ent_t;

  ent_t mq[$];
  bit   m_prev = 0;
  bit   m_ovf = 0;
  bit   m_irq = 0;
  int   m_seq = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit push;
    bit drop;
    ent_t e;
    if (!rstn_i) begin
      mq.delete();
      m_prev = 0; m_ovf = 0; m_irq = 0; m_seq = 0;
      return;
    end
    push = event_i && !m_prev;
    m_prev = event_i;
    m_irq = irq_enable_i && (mq.size() != 0 || m_ovf);
    if (pop_i && mq.size() > 0) void'(mq.pop_front());
    drop = 0;
    if (push) begin
      if (mq.size() < DEPTH) begin
        e.d = date_i; e.c = clock_i; e.s = 8'(m_seq);
        mq.push_back(e);
      end else drop = 1;
      m_seq = (m_seq + 1) % 256;
    end
    if (drop) m_ovf = 1;
    else if (clear_overflow_i) m_ovf = 0;
  endtask

  task automatic check_all(input string tag);
    bit ne;
    ne = (mq.size() != 0);
    chk({tag, ".valid"}, valid_o, ne);
    chk({tag, ".date"}, ts_date_o, ne ? mq[0].d : 32'h0);
    chk({tag, ".clock"}, ts_clock_o, ne ? mq[0].c : 22'h0);
    chk({tag, ".count"}, count_o, mq.size());
    chk({tag, ".ovf"}, overflow_o, m_ovf);
    chk({tag, ".irq"}, irq_o, m_irq);
`ifdef RTC_EVT_LOG_SEQ_EN
    chk({tag, ".seq"}, seq_o, ne ? mq[0].s : 8'h0);
`endif
  endtask

  task automatic step(input logic ev, input logic [31:0] d, input logic [21:0] c,
                      input logic pop, input logic clr, input string tag);
    @(negedge clk);
    event_i = ev; date_i = d; clock_i = c; pop_i = pop; clear_overflow_i = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    step(0, 0, 0, 0, 0, "rst");
    step(0, 0, 0, 0, 0, "rst");
    rstn_i = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);

    // Single capture
    step(1, 32'h20240115, 22'h123456, 0, 0, "cap");
    chk("cap_valid", valid_o, 1);
    chk("cap_date", ts_date_o, 32'h20240115);
    chk("cap_clock", ts_clock_o, 22'h123456);
    chk("cap_count", count_o, 1);
    step(0, 0, 0, 1, 0, "cap_pop");

    // Held level: one entry
    for (int i = 0; i < 5; i++) step(1, 32'h100 + i, 22'h10 + i, 0, 0, "hold");
    step(0, 0, 0, 0, 0, "hold_end");
    chk("hold_count", count_o, 1);
    chk("hold_date", ts_date_o, 32'h100);

    // Overflow on DEPTH+1 events
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h1000 + i, 22'h2000 + i, 0, 0, "fill");
      step(0, 0, 0, 0, 0, "fill_gap");
    end
    chk("ovf_count", count_o, 4);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_head", ts_date_o, 32'h1000);
    step(0, 0, 0, 0, 1, "ovf_clr");
    chk("ovf_cleared", overflow_o, 0);

    // Full, push and pop together
    step(1, 32'h1005, 22'h2005, 1, 0, "full_pp");
    chk("fullpp_count", count_o, 4);
    chk("fullpp_ovf", overflow_o, 0);
    chk("fullpp_head", ts_date_o, 32'h1001);

    // Empty, push and pop together; clear racing a drop
    do_reset();
    step(1, 32'hAAAA, 22'h1, 1, 0, "empty_pp");
    chk("emptypp_count", count_o, 1);
    step(0, 0, 0, 0, 0, "gap");
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hB0 + i, 22'h3, 0, 0, "fill2");
      step(0, 0, 0, 0, 0, "fill2_gap");
    end
    chk("drop_ovf", overflow_o, 1);
    step(1, 32'hCC, 22'h4, 0, 1, "clr_vs_drop");
    chk("clr_vs_drop_ovf", overflow_o, 1);

    // IRQ latency
    do_reset();
    irq_enable_i = 1'b1;
    step(1, 32'h55, 22'h66, 0, 0, "irq_ev");
    chk("irq_valid_up", valid_o, 1);
    chk("irq_not_yet", irq_o, 0);
    step(0, 0, 0, 0, 0, "irq_rise");
    chk("irq_up", irq_o, 1);
    step(0, 0, 0, 1, 0, "irq_pop");
    chk("irq_valid_dn", valid_o, 0);
    chk("irq_still", irq_o, 1);
    step(0, 0, 0, 0, 0, "irq_fall");
    chk("irq_dn", irq_o, 0);
    step(0, 0, 0, 1, 0, "pop_empty");
    chk("pop_empty_count", count_o, 0);
    irq_enable_i = 1'b0;

`ifdef RTC_EVT_LOG_SEQ_EN
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h700 + i, 22'h7, 0, 0, "seq_fill");
      step(0, 0, 0, 0, 0, "seq_gap");
    end
    for (int i = 0; i < 4; i++) begin
      chk("seq_drain", seq_o, i);
      step(0, 0, 0, 1, 0, "seq_pop");
    end
    step(1, 32'h7FF, 22'h7, 0, 0, "seq_next");
    chk("seq_after_gap", seq_o, 6);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) rstn_i = 1'b0;
      else rstn_i = 1'b1;
      if ($urandom_range(0, 9) == 0) irq_enable_i = $urandom_range(0, 1);
      step($urandom_range(0, 2) == 0, $urandom, 22'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_evt_log.md
Name: rtc_evt_log

Overview:
- Timestamped event logger directly downstream of the RTC core.
- Consumes the alarm/timer event pulse plus the live date and clock words that the RTC core produces.
- On each event, captures {date, clock} into a small FIFO, which software or the register interface then drains.
- Raises an interrupt while entries are pending or an overflow has occurred.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_W, $clog2(DEPTH+1), width of count_o; derived, not overridden.

Ports:
clk_i  in  1  single clock.
rstn_i  in  1  reset; synchronous, active-low.
event_i  in  1  event from RTC core; may be held high for more than one cycle.
date_i  in  32  live RTC date word.
clock_i  in  22  live RTC clock word.
irq_enable_i  in  1  interrupt enable.
pop_i  in  1  remove head entry.
clear_overflow_i  in  1  clear the sticky overflow flag.
valid_o  out  1  FIFO not empty.
ts_date_o  out  32  date field of the head entry; 0 when empty.
ts_clock_o  out  22  clock field of the head entry; 0 when empty.
count_o  out  CNT_W  number of stored entries.
overflow_o  out  1  sticky flag: an event was dropped.
irq_o  out  1  registered interrupt, level.

Behaviour:
- Reset (rstn_i low at a clock edge):
  - FIFO empties; edge register evt_q clears to 0.
  - All outputs are 0 on the following cycle.
  - Reset mid-operation discards every entry and the overflow flag.
- Edge detect:
  - push = event_i & ~evt_q; evt_q <= event_i each cycle.
  - A level held N cycles produces exactly one push.
- Capture:
  - On push, {date_i, clock_i} sampled in the same cycle is written at the tail.
  - Entry is visible one cycle later: valid_o = 1, head on ts_*_o, count_o incremented.
- Pop:
  - pop_i & valid_o removes the head at the clock edge.
  - pop_i while empty is ignored; no underflow, no pointer movement.
- Full, no pop:
  - Push is dropped; the oldest entries are kept.
  - overflow_o sets on the next cycle.
- Simultaneous events:
  - Full with push and pop together: pop takes effect and the push is accepted; count stays DEPTH, no overflow.
  - Empty with push and pop together: push accepted; pop ignored.
  - clear_overflow_i and a new drop in the same cycle: set wins, overflow_o stays 1.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH, with a separate occupancy counter in range 0..DEPTH.
- IRQ: irq_o <= irq_enable_i & (count != 0 | overflow); one-cycle latency from any change.
- No combinational path from pop_i or event_i to any output.

Optional Feature:
- Macro: RTC_EVT_LOG_SEQ_EN.
- Defined:
  - Extra output seq_o [7:0] carries the sequence number of the head entry; 0 when empty.
  - An 8-bit counter increments on every detected edge, including dropped ones, and wraps 255 -> 0.
  - The counter value is stored with each entry, so software detects gaps.
  - The counter resets to 0.
- Undefined: no seq_o port, no counter; behaviour is otherwise identical.

Decomposition:
- Package rtc_evt_pkg:
  - Constants RTC_DATE_W = 32 and RTC_CLOCK_W = 22.
  - Packed struct rtc_ts_t {date, clock, plus seq under the macro}.
- Sub-module rtc_evt_fifo: generic synchronous FIFO of rtc_ts_t with push, pop, full, empty and count.
- The top holds the edge detect, overflow flag and irq logic.

Test Plan:
- Reset, then event_i pulse with date_i = 0x20240115, clock_i = 0x123456 -> next cycle valid_o = 1, ts_date_o = 0x20240115, ts_clock_o = 0x123456, count_o = 1.
- event_i held high for 5 cycles -> exactly one entry, count_o = 1.
- DEPTH = 4, 5 separated events with no pop -> count_o = 4, overflow_o = 1, head = first event's timestamp; clear_overflow_i -> overflow_o = 0.
- Full FIFO, edge and pop_i in the same cycle -> count_o stays 4, overflow_o stays 0, head advances to the second entry.
- irq_enable_i = 1, one event -> irq_o rises one cycle after valid_o; pop_i -> irq_o falls one cycle after valid_o falls; pop_i while empty -> count_o stays 0.
- With RTC_EVT_LOG_SEQ_EN, 6 events on DEPTH = 4 with no pop, then drain -> seq_o reads 0, 1, 2, 3; next event stores seq 6.
